// File: rtl/router_vc_input_buffer.sv
// -----------------------------------------------------------------------------
// router_vc_input_buffer
//
// Per-port input stage of the mesh router. Holds two virtual-channel FIFOs
// (VC0 = even, VC1 = odd). The router-wide polarity decides which VC each side
// may use in a given cycle. The link side writes VC ~polarity, and the crossbar
// side reads VC polarity, so a write and a read never touch the same VC.
//
// Optional feature (compile-time macro ROUTER_VC_HOPCNT_EN):
//   When defined, the 8-bit hop-count field at [HOP_LSB+7:HOP_LSB] is
//   incremented on enqueue and saturates at 8'hFF. When undefined, packets are
//   stored verbatim.
//
// Ports:
//   clk       router clock
//   reset     asynchronous, active-low reset
//   polarity  router polarity (link writes VC ~polarity, crossbar reads VC polarity)
//   si        upstream send strobe
//   di        upstream packet
//   ri        ready to upstream (link-side VC not full)
//   req       head of VC[polarity] valid toward the crossbar
//   dout      head of VC[polarity], zero when req is low
//   gnt       crossbar accepts dout this cycle
//   cnt0      occupancy of VC0 (registered)
//   cnt1      occupancy of VC1 (registered)
//   err       sticky protocol-error flag (wrong-phase or overflow send)
// -----------------------------------------------------------------------------
module router_vc_input_buffer #(
    parameter int DATA_WIDTH   = 64,
    parameter int BUFFER_DEPTH = 4,
    parameter int VC_BIT       = 63,
    parameter int HOP_LSB      = 48
) (
    input  logic                                  clk,
    input  logic                                  reset,
    input  logic                                  polarity,
    input  logic                                  si,
    input  logic [DATA_WIDTH-1:0]                 di,
    output logic                                  ri,
    output logic                                  req,
    output logic [DATA_WIDTH-1:0]                 dout,
    input  logic                                  gnt,
    output logic [$clog2(BUFFER_DEPTH+1)-1:0]     cnt0,
    output logic [$clog2(BUFFER_DEPTH+1)-1:0]     cnt1,
    output logic                                  err
);

    localparam int CW = $clog2(BUFFER_DEPTH + 1);
    localparam int PW = (BUFFER_DEPTH > 1) ? $clog2(BUFFER_DEPTH) : 1;
    localparam logic [CW-1:0] FULL_COUNT = CW'(BUFFER_DEPTH);
    localparam logic [PW-1:0] LAST_SLOT  = PW'(BUFFER_DEPTH - 1);

    // Storage and bookkeeping, indexed by VC number
    logic [DATA_WIDTH-1:0] mem    [2][BUFFER_DEPTH];
    logic [PW-1:0]         wr_ptr [2];
    logic [PW-1:0]         rd_ptr [2];
    logic [CW-1:0]         count  [2];

    logic                  link_vc;
    logic                  phase_ok;
    logic                  enq;
    logic                  deq;
    logic [7:0]            hop_cur;
    logic [7:0]            hop_next;
    logic [DATA_WIDTH-1:0] store_word;
    logic [DATA_WIDTH-1:0] head;

    // Depth need not be a power of two, so wrap by explicit compare
    function automatic logic [PW-1:0] next_ptr(input logic [PW-1:0] p);
        return (p == LAST_SLOT) ? '0 : p + PW'(1);
    endfunction

    // The link-side VC for this cycle is always the one not being read
    assign link_vc  = ~polarity;
    assign ri       = (count[link_vc] != FULL_COUNT);
    assign req      = (count[polarity] != '0);
    assign phase_ok = (di[VC_BIT] == link_vc);
    assign enq      = si & phase_ok & ri;
    assign deq      = gnt & req;

    // Head of the crossbar-side VC, forced to zero whenever nothing is offered
    assign head = mem[polarity][rd_ptr[polarity]];
    assign dout = req ? head : '0;

    assign cnt0 = count[0];
    assign cnt1 = count[1];

    // Hop-count handling. The default build rewrites the field with its own
    // value, which leaves the stored word identical to di.
    assign hop_cur = di[HOP_LSB +: 8];
`ifdef ROUTER_VC_HOPCNT_EN
    assign hop_next = (hop_cur == 8'hFF) ? 8'hFF : hop_cur + 8'd1;
`else
    assign hop_next = hop_cur;
`endif

    always_comb begin
        store_word                = di;
        store_word[HOP_LSB +: 8]  = hop_next;
    end

    // Packet storage carries no reset; dout is masked by req, so stale
    // contents are never visible
    always_ff @(posedge clk) begin
        if (enq) begin
            mem[link_vc][wr_ptr[link_vc]] <= store_word;
        end
    end

    // Pointers, counts and the sticky error flag. Enqueue and dequeue hit
    // different VCs, so both updates can land on the same edge without
    // contending for a count.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int v = 0; v < 2; v++) begin
                wr_ptr[v] <= '0;
                rd_ptr[v] <= '0;
                count[v]  <= '0;
            end
            err <= 1'b0;
        end else begin
            if (enq) begin
                wr_ptr[link_vc] <= next_ptr(wr_ptr[link_vc]);
                count[link_vc]  <= count[link_vc] + CW'(1);
            end
            if (deq) begin
                rd_ptr[polarity] <= next_ptr(rd_ptr[polarity]);
                count[polarity]  <= count[polarity] - CW'(1);
            end
            // A send that is not accepted is either wrong-phase or an overflow
            if (si && !enq) begin
                err <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_router_vc_input_buffer.sv
// -----------------------------------------------------------------------------
// tb_router_vc_input_buffer
//
// Directed bench for router_vc_input_buffer with the default parameters
// (64-bit packets, 4 entries per VC, VC bit 63, hop field at [55:48]).
// Expected hop values follow ROUTER_VC_HOPCNT_EN when it is defined.
// -----------------------------------------------------------------------------
module tb_router_vc_input_buffer;

    logic        clk;
    logic        reset;
    logic        polarity;
    logic        si;
    logic [63:0] di;
    logic        ri;
    logic        req;
    logic [63:0] dout;
    logic        gnt;
    logic [2:0]  cnt0;
    logic [2:0]  cnt1;
    logic        err;

    int checks = 0;
    int errors = 0;

    router_vc_input_buffer dut (
        .clk      (clk),
        .reset    (reset),
        .polarity (polarity),
        .si       (si),
        .di       (di),
        .ri       (ri),
        .req      (req),
        .dout     (dout),
        .gnt      (gnt),
        .cnt0     (cnt0),
        .cnt1     (cnt1),
        .err      (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Build a packet: VC bit, hop count, 48-bit payload
    function automatic logic [63:0] mk(input logic vc, input logic [47:0] payload, input logic [7:0] hop);
        return {vc, 7'b0, hop, payload};
    endfunction

    // The word expected on dout for a given enqueued packet
    function automatic logic [63:0] expWord(input logic [63:0] w);
        logic [63:0] r;
        r = w;
`ifdef ROUTER_VC_HOPCNT_EN
        if (r[55:48] != 8'hFF) r[55:48] = r[55:48] + 8'd1;
`endif
        return r;
    endfunction

    task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        checks++;
        if (observed !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %h expected %h", tag, observed, expected);
        end
    endtask

    // Drive inputs and let combinational outputs settle
    task automatic applyStimulus(input logic pol, input logic s, input logic [63:0] d, input logic g);
        polarity = pol;
        si       = s;
        di       = d;
        gnt      = g;
        #1;
    endtask

    // Advance one edge, then sample registered outputs away from it
    task automatic clockEdge();
        @(posedge clk);
        #1;
        si  = 1'b0;
        gnt = 1'b0;
    endtask

    logic [63:0] w1;
    logic [63:0] w2;
    logic        tabPol  [9] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1};
    int          tabSend [9] = '{1, 2, 3, 4, 5, 6, 0, 0, 0};
    int          tabExp  [9] = '{0, 0, 1, 3, 2, 4, 5, 6, 0};

    initial begin
        reset    = 1'b0;
        polarity = 1'b0;
        si       = 1'b0;
        di       = '0;
        gnt      = 1'b0;
        w1 = {1'b1, 2'b00, 5'b0, 8'h11, 16'h0201, 32'hAAAA_AAAA};
        w2 = mk(1'b1, 48'h55, 8'hFF);

        // Reset state
        #3;
        checkOutput("rst_req",  64'(req),  64'd0);
        checkOutput("rst_dout", dout,      64'd0);
        checkOutput("rst_ri",   64'(ri),   64'd1);
        checkOutput("rst_cnt0", 64'(cnt0), 64'd0);
        checkOutput("rst_cnt1", 64'(cnt1), 64'd0);
        checkOutput("rst_err",  64'(err),  64'd0);
        @(negedge clk);
        reset = 1'b1;
        clockEdge();

        // Single packet into VC1, visible the cycle polarity flips to 1
        applyStimulus(1'b0, 1'b1, w1, 1'b0);
        checkOutput("w1_ri", 64'(ri), 64'd1);
        clockEdge();
        checkOutput("w1_cnt1", 64'(cnt1), 64'd1);
        checkOutput("w1_err",  64'(err),  64'd0);
        applyStimulus(1'b1, 1'b0, 64'd0, 1'b1);
        checkOutput("w1_req",  64'(req), 64'd1);
        checkOutput("w1_dout", dout, expWord(w1));
        clockEdge();
        checkOutput("w1_pop_cnt1", 64'(cnt1), 64'd0);
        applyStimulus(1'b1, 1'b0, 64'd0, 1'b0);
        checkOutput("w1_empty_req",  64'(req), 64'd0);
        checkOutput("w1_empty_dout", dout, 64'd0);

        // Saturated hop field
        applyStimulus(1'b0, 1'b1, w2, 1'b0);
        clockEdge();
        applyStimulus(1'b1, 1'b0, 64'd0, 1'b1);
        checkOutput("hopff_dout", dout, expWord(w2));
        clockEdge();

        // Fill VC0, then overflow
        for (int i = 0; i < 4; i++) begin
            applyStimulus(1'b1, 1'b1, mk(1'b0, 48'(16 + i), 8'h00), 1'b0);
            clockEdge();
        end
        checkOutput("full_cnt0", 64'(cnt0), 64'd4);
        applyStimulus(1'b1, 1'b0, 64'd0, 1'b0);
        checkOutput("full_ri",  64'(ri),  64'd0);
        checkOutput("full_err", 64'(err), 64'd0);
        applyStimulus(1'b1, 1'b1, mk(1'b0, 48'd99, 8'h00), 1'b0);
        clockEdge();
        checkOutput("ovf_err",  64'(err),  64'd1);
        checkOutput("ovf_cnt0", 64'(cnt0), 64'd4);
        applyStimulus(1'b0, 1'b0, 64'd0, 1'b0);
        checkOutput("full_ri_pol0", 64'(ri), 64'd1);
        checkOutput("full_head",    dout, expWord(mk(1'b0, 48'd16, 8'h00)));

        // Asynchronous reset clears everything without an edge
        #1;
        reset = 1'b0;
        #1;
        checkOutput("arst_cnt0", 64'(cnt0), 64'd0);
        checkOutput("arst_err",  64'(err),  64'd0);
        checkOutput("arst_req",  64'(req),  64'd0);
        @(negedge clk);
        reset = 1'b1;
        clockEdge();

        // Wrong-phase send
        applyStimulus(1'b0, 1'b1, mk(1'b0, 48'd7, 8'h00), 1'b0);
        clockEdge();
        checkOutput("wp_err",  64'(err),  64'd1);
        checkOutput("wp_cnt0", 64'(cnt0), 64'd0);
        checkOutput("wp_cnt1", 64'(cnt1), 64'd0);

        // Reset with 3 packets held in VC1
        for (int i = 0; i < 3; i++) begin
            applyStimulus(1'b0, 1'b1, mk(1'b1, 48'(8'h31 + i), 8'h00), 1'b0);
            clockEdge();
        end
        checkOutput("mid_cnt1", 64'(cnt1), 64'd3);
        applyStimulus(1'b1, 1'b0, 64'd0, 1'b0);
        checkOutput("mid_req", 64'(req), 64'd1);
        reset = 1'b0;
        #1;
        checkOutput("mid_rst_cnt1", 64'(cnt1), 64'd0);
        checkOutput("mid_rst_req",  64'(req),  64'd0);
        checkOutput("mid_rst_err",  64'(err),  64'd0);
        @(negedge clk);
        reset = 1'b1;
        clockEdge();

        // First packets after reset become the new head, drained in order
        applyStimulus(1'b0, 1'b1, mk(1'b1, 48'h41, 8'h00), 1'b0);
        clockEdge();
        applyStimulus(1'b0, 1'b1, mk(1'b1, 48'h42, 8'h00), 1'b0);
        clockEdge();
        applyStimulus(1'b1, 1'b0, 64'd0, 1'b1);
        checkOutput("post_rst_head", dout, expWord(mk(1'b1, 48'h41, 8'h00)));
        clockEdge();
        applyStimulus(1'b1, 1'b0, 64'd0, 1'b1);
        checkOutput("post_rst_second", dout, expWord(mk(1'b1, 48'h42, 8'h00)));
        clockEdge();
        checkOutput("post_rst_cnt1", 64'(cnt1), 64'd0);

        // Move VC0 pointers to slot 2 so the interleave wraps both VCs
        applyStimulus(1'b1, 1'b1, mk(1'b0, 48'hD1, 8'h00), 1'b0);
        clockEdge();
        applyStimulus(1'b1, 1'b1, mk(1'b0, 48'hD2, 8'h00), 1'b0);
        clockEdge();
        applyStimulus(1'b0, 1'b0, 64'd0, 1'b1);
        checkOutput("d1_dout", dout, expWord(mk(1'b0, 48'hD1, 8'h00)));
        clockEdge();
        applyStimulus(1'b0, 1'b0, 64'd0, 1'b1);
        checkOutput("d2_dout", dout, expWord(mk(1'b0, 48'hD2, 8'h00)));
        clockEdge();
        checkOutput("d_cnt0", 64'(cnt0), 64'd0);

        // Interleaved traffic with a pop on every eligible cycle
        for (int c = 0; c < 9; c++) begin
            applyStimulus(tabPol[c], (tabSend[c] != 0),
                          mk(~tabPol[c], 48'(tabSend[c]), 8'h00), 1'b1);
            checkOutput($sformatf("il_req_c%0d", c), 64'(req), 64'(tabExp[c] != 0));
            checkOutput($sformatf("il_dout_c%0d", c), dout,
                        (tabExp[c] != 0) ? expWord(mk(tabPol[c], 48'(tabExp[c]), 8'h00)) : 64'd0);
            clockEdge();
        end
        checkOutput("il_cnt0", 64'(cnt0), 64'd0);
        checkOutput("il_cnt1", 64'(cnt1), 64'd0);
        checkOutput("il_err",  64'(err),  64'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
